// File: rtl/multi_target_tracker.sv
// N-slot alpha-beta multi-object tracker: gated nearest-neighbour association,
// track birth/coasting/deletion, per-frame predict and dump of confirmed tracks.
module multi_target_tracker #(
    parameter int N_TRACKS = 16,
    parameter int POS_W    = 32,
    parameter int CLASS_W  = 8,
    parameter int ALPHA_SH = 1,
    parameter int BETA_SH  = 3,
    parameter int GATE     = 256,
    parameter int MAX_MISS = 3,
    parameter int CONFIRM  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_tick,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [POS_W-1:0]            in_x,
    input  logic [POS_W-1:0]            in_y,
    input  logic [CLASS_W-1:0]          in_class,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(N_TRACKS)-1:0] out_id,
    output logic [POS_W-1:0]            out_x,
    output logic [POS_W-1:0]            out_y,
    output logic [POS_W-1:0]            out_vx,
    output logic [POS_W-1:0]            out_vy,
    output logic [CLASS_W-1:0]          out_class,
    output logic                        frame_done,
    output logic                        meas_dropped,
    output logic                        frame_overrun
);

    localparam int ID_W   = $clog2(N_TRACKS);
    localparam int MISS_W = $clog2(MAX_MISS + 2);
    localparam int HIT_W  = $clog2(CONFIRM + 1);
    localparam logic [ID_W-1:0]    LAST_IDX = ID_W'(N_TRACKS - 1);
    localparam logic [POS_W+1:0]   GATE_L   = (POS_W + 2)'(GATE);
    localparam logic [MISS_W-1:0]  MISS_SAT = MISS_W'(MAX_MISS + 1);
    localparam logic [MISS_W-1:0]  MISS_LIM = MISS_W'(MAX_MISS);
    localparam logic [HIT_W-1:0]   HIT_SAT  = HIT_W'(CONFIRM);

    typedef logic signed [POS_W-1:0] pos_t;
    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_UPDATE, S_PREDICT, S_DUMP} state_t;

    function automatic pos_t sat_pos(input logic signed [POS_W+1:0] v);
        if (v > $signed({3'b000, {(POS_W-1){1'b1}}})) begin
            return {1'b0, {(POS_W-1){1'b1}}};
        end else if (v < $signed({3'b111, {(POS_W-1){1'b0}}})) begin
            return {1'b1, {(POS_W-1){1'b0}}};
        end else begin
            return v[POS_W-1:0];
        end
    endfunction

    function automatic logic [POS_W:0] abs_res(input logic signed [POS_W:0] v);
        if (v[POS_W]) begin
            return ~v + {{POS_W{1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    function automatic logic signed [POS_W+1:0] ext_pos(input pos_t v);
        return {{2{v[POS_W-1]}}, v};
    endfunction

    function automatic logic signed [POS_W+1:0] ext_res(input logic signed [POS_W:0] v);
        return {v[POS_W], v};
    endfunction

    state_t             state_q, state_d;
    logic [ID_W-1:0]    idx_q, idx_d;
    logic               pending_q, pending_d;
    pos_t               det_x_q, det_x_d, det_y_q, det_y_d;
    logic [CLASS_W-1:0] det_class_q, det_class_d;
    logic               best_found_q, best_found_d;
    logic [ID_W-1:0]    best_idx_q, best_idx_d;
    logic [POS_W+1:0]   best_dist_q, best_dist_d;
    logic               free_found_q, free_found_d;
    logic [ID_W-1:0]    free_idx_q, free_idx_d;

    logic               valid_q   [N_TRACKS];
    logic               valid_d   [N_TRACKS];
    pos_t               x_q       [N_TRACKS];
    pos_t               x_d       [N_TRACKS];
    pos_t               y_q       [N_TRACKS];
    pos_t               y_d       [N_TRACKS];
    pos_t               vx_q      [N_TRACKS];
    pos_t               vx_d      [N_TRACKS];
    pos_t               vy_q      [N_TRACKS];
    pos_t               vy_d      [N_TRACKS];
    logic [CLASS_W-1:0] class_q   [N_TRACKS];
    logic [CLASS_W-1:0] class_d   [N_TRACKS];
    logic [MISS_W-1:0]  miss_q    [N_TRACKS];
    logic [MISS_W-1:0]  miss_d    [N_TRACKS];
    logic [HIT_W-1:0]   hits_q    [N_TRACKS];
    logic [HIT_W-1:0]   hits_d    [N_TRACKS];
    logic               matched_q [N_TRACKS];
    logic               matched_d [N_TRACKS];

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    pos_t               out_x_q, out_x_d, out_y_q, out_y_d;
    pos_t               out_vx_q, out_vx_d, out_vy_q, out_vy_d;
    logic [CLASS_W-1:0] out_class_q, out_class_d;
    logic               frame_done_q, frame_done_d;
    logic               meas_dropped_q, meas_dropped_d;
    logic               frame_overrun_q, frame_overrun_d;

    logic [ID_W-1:0]       sel_idx_s;
    pos_t                  sel_x_s, sel_y_s, sel_vx_s, sel_vy_s;
    logic signed [POS_W:0] dx_s, dy_s;
    logic [POS_W+1:0]      dist_s;
    pos_t                  upd_x_s, upd_y_s, upd_vx_s, upd_vy_s;
    pos_t                  pred_x_s, pred_y_s;
    logic [MISS_W-1:0]     miss_next_s;
    logic [HIT_W-1:0]      hits_next_s;
    logic                  qualify_s;

    // Shared slot datapath: residuals, filter update, prediction and dump qualification
    always_comb begin
        sel_idx_s   = (state_q == S_UPDATE) ? best_idx_q : idx_q;
        sel_x_s     = x_q[sel_idx_s];
        sel_y_s     = y_q[sel_idx_s];
        sel_vx_s    = vx_q[sel_idx_s];
        sel_vy_s    = vy_q[sel_idx_s];
        dx_s        = $signed({det_x_q[POS_W-1], det_x_q}) - $signed({sel_x_s[POS_W-1], sel_x_s});
        dy_s        = $signed({det_y_q[POS_W-1], det_y_q}) - $signed({sel_y_s[POS_W-1], sel_y_s});
        dist_s      = {1'b0, abs_res(dx_s)} + {1'b0, abs_res(dy_s)};
        upd_x_s     = sat_pos(ext_pos(sel_x_s) + ext_res(dx_s >>> ALPHA_SH));
        upd_y_s     = sat_pos(ext_pos(sel_y_s) + ext_res(dy_s >>> ALPHA_SH));
        upd_vx_s    = sat_pos(ext_pos(sel_vx_s) + ext_res(dx_s >>> BETA_SH));
        upd_vy_s    = sat_pos(ext_pos(sel_vy_s) + ext_res(dy_s >>> BETA_SH));
        pred_x_s    = sat_pos(ext_pos(sel_x_s) + ext_pos(sel_vx_s));
        pred_y_s    = sat_pos(ext_pos(sel_y_s) + ext_pos(sel_vy_s));
        // A slot associated since the last tick keeps its miss count
        if (matched_q[sel_idx_s] || (miss_q[sel_idx_s] >= MISS_SAT)) begin
            miss_next_s = miss_q[sel_idx_s];
        end else begin
            miss_next_s = miss_q[sel_idx_s] + MISS_W'(1);
        end
        if (hits_q[sel_idx_s] >= HIT_SAT) begin
            hits_next_s = hits_q[sel_idx_s];
        end else begin
            hits_next_s = hits_q[sel_idx_s] + HIT_W'(1);
        end
        qualify_s = valid_q[sel_idx_s] && (hits_q[sel_idx_s] >= HIT_SAT);
    end

    // Next-state logic for the controller, the track table and the registered outputs
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pending_d       = pending_q;
        det_x_d         = det_x_q;
        det_y_d         = det_y_q;
        det_class_d     = det_class_q;
        best_found_d    = best_found_q;
        best_idx_d      = best_idx_q;
        best_dist_d     = best_dist_q;
        free_found_d    = free_found_q;
        free_idx_d      = free_idx_q;
        valid_d         = valid_q;
        x_d             = x_q;
        y_d             = y_q;
        vx_d            = vx_q;
        vy_d            = vy_q;
        class_d         = class_q;
        miss_d          = miss_q;
        hits_d          = hits_q;
        matched_d       = matched_q;
        out_valid_d     = out_valid_q;
        out_id_d        = out_id_q;
        out_x_d         = out_x_q;
        out_y_d         = out_y_q;
        out_vx_d        = out_vx_q;
        out_vy_d        = out_vy_q;
        out_class_d     = out_class_q;
        frame_done_d    = 1'b0;
        meas_dropped_d  = 1'b0;
        frame_overrun_d = 1'b0;

        if (frame_tick) begin
            if (pending_q) begin
                frame_overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_PREDICT;
                    idx_d     = {ID_W{1'b0}};
                    pending_d = 1'b0;
                end else if (in_valid && in_ready_q) begin
                    state_d      = S_SEARCH;
                    idx_d        = {ID_W{1'b0}};
                    det_x_d      = in_x;
                    det_y_d      = in_y;
                    det_class_d  = in_class;
                    best_found_d = 1'b0;
                    free_found_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                // Strict less-than keeps the lowest index on equal distances
                if (valid_q[idx_q] && (dist_s <= GATE_L) &&
                    (!best_found_q || (dist_s < best_dist_q))) begin
                    best_found_d = 1'b1;
                    best_idx_d   = idx_q;
                    best_dist_d  = dist_s;
                end else begin
                    best_found_d = best_found_q;
                end
                if (!valid_q[idx_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end else begin
                    free_found_d = free_found_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_UPDATE;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            S_UPDATE: begin
                if (best_found_q) begin
                    x_d[best_idx_q]       = upd_x_s;
                    y_d[best_idx_q]       = upd_y_s;
                    vx_d[best_idx_q]      = upd_vx_s;
                    vy_d[best_idx_q]      = upd_vy_s;
                    miss_d[best_idx_q]    = {MISS_W{1'b0}};
                    hits_d[best_idx_q]    = hits_next_s;
                    class_d[best_idx_q]   = det_class_q;
                    matched_d[best_idx_q] = 1'b1;
                end else if (free_found_q) begin
                    valid_d[free_idx_q]   = 1'b1;
                    x_d[free_idx_q]       = det_x_q;
                    y_d[free_idx_q]       = det_y_q;
                    vx_d[free_idx_q]      = {POS_W{1'b0}};
                    vy_d[free_idx_q]      = {POS_W{1'b0}};
                    miss_d[free_idx_q]    = {MISS_W{1'b0}};
                    hits_d[free_idx_q]    = HIT_W'(1);
                    class_d[free_idx_q]   = det_class_q;
                    matched_d[free_idx_q] = 1'b1;
                end else begin
                    meas_dropped_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_PREDICT: begin
                if (valid_q[idx_q]) begin
                    x_d[idx_q]       = pred_x_s;
                    y_d[idx_q]       = pred_y_s;
                    miss_d[idx_q]    = miss_next_s;
                    matched_d[idx_q] = 1'b0;
                    valid_d[idx_q]   = (miss_next_s <= MISS_LIM);
                end else begin
                    matched_d[idx_q] = 1'b0;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DUMP;
                    idx_d   = {ID_W{1'b0}};
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            S_DUMP: begin
                // Each record is held until accepted; non-qualifying slots take one cycle
                if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            idx_d = idx_q + ID_W'(1);
                        end
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end else if (qualify_s) begin
                    out_valid_d = 1'b1;
                    out_id_d    = idx_q;
                    out_x_d     = sel_x_s;
                    out_y_d     = sel_y_s;
                    out_vx_d    = sel_vx_s;
                    out_vy_d    = sel_vy_s;
                    out_class_d = class_q[idx_q];
                end else if (idx_q == LAST_IDX) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE) && !pending_d;
    end

    // State, track table and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            idx_q           <= {ID_W{1'b0}};
            pending_q       <= 1'b0;
            det_x_q         <= {POS_W{1'b0}};
            det_y_q         <= {POS_W{1'b0}};
            det_class_q     <= {CLASS_W{1'b0}};
            best_found_q    <= 1'b0;
            best_idx_q      <= {ID_W{1'b0}};
            best_dist_q     <= {(POS_W+2){1'b0}};
            free_found_q    <= 1'b0;
            free_idx_q      <= {ID_W{1'b0}};
            for (int i = 0; i < N_TRACKS; i++) begin
                valid_q[i]   <= 1'b0;
                x_q[i]       <= {POS_W{1'b0}};
                y_q[i]       <= {POS_W{1'b0}};
                vx_q[i]      <= {POS_W{1'b0}};
                vy_q[i]      <= {POS_W{1'b0}};
                class_q[i]   <= {CLASS_W{1'b0}};
                miss_q[i]    <= {MISS_W{1'b0}};
                hits_q[i]    <= {HIT_W{1'b0}};
                matched_q[i] <= 1'b0;
            end
            in_ready_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_id_q        <= {ID_W{1'b0}};
            out_x_q         <= {POS_W{1'b0}};
            out_y_q         <= {POS_W{1'b0}};
            out_vx_q        <= {POS_W{1'b0}};
            out_vy_q        <= {POS_W{1'b0}};
            out_class_q     <= {CLASS_W{1'b0}};
            frame_done_q    <= 1'b0;
            meas_dropped_q  <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            det_x_q         <= det_x_d;
            det_y_q         <= det_y_d;
            det_class_q     <= det_class_d;
            best_found_q    <= best_found_d;
            best_idx_q      <= best_idx_d;
            best_dist_q     <= best_dist_d;
            free_found_q    <= free_found_d;
            free_idx_q      <= free_idx_d;
            valid_q         <= valid_d;
            x_q             <= x_d;
            y_q             <= y_d;
            vx_q            <= vx_d;
            vy_q            <= vy_d;
            class_q         <= class_d;
            miss_q          <= miss_d;
            hits_q          <= hits_d;
            matched_q       <= matched_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            out_id_q        <= out_id_d;
            out_x_q         <= out_x_d;
            out_y_q         <= out_y_d;
            out_vx_q        <= out_vx_d;
            out_vy_q        <= out_vy_d;
            out_class_q     <= out_class_d;
            frame_done_q    <= frame_done_d;
            meas_dropped_q  <= meas_dropped_d;
            frame_overrun_q <= frame_overrun_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_id        = out_id_q;
    assign out_x         = out_x_q;
    assign out_y         = out_y_q;
    assign out_vx        = out_vx_q;
    assign out_vy        = out_vy_q;
    assign out_class     = out_class_q;
    assign frame_done    = frame_done_q;
    assign meas_dropped  = meas_dropped_q;
    assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_multi_target_tracker.sv
// Scoreboard bench for multi_target_tracker: directed detections and ticks push
// expected dump records; a negedge monitor pops and compares them.
module tb_multi_target_tracker;

    localparam int N       = 16;
    localparam int POS_W   = 32;
    localparam int CLASS_W = 8;
    localparam int ID_W    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [POS_W-1:0] in_x = '0;
    logic signed [POS_W-1:0] in_y = '0;
    logic [CLASS_W-1:0] in_class = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [ID_W-1:0] out_id;
    logic signed [POS_W-1:0] out_x, out_y, out_vx, out_vy;
    logic [CLASS_W-1:0] out_class;
    logic frame_done, meas_dropped, frame_overrun;

    always #5 clk = ~clk;

    multi_target_tracker #(
        .N_TRACKS(N), .POS_W(POS_W), .CLASS_W(CLASS_W), .ALPHA_SH(1), .BETA_SH(3),
        .GATE(256), .MAX_MISS(3), .CONFIRM(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_class(in_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_x(out_x), .out_y(out_y), .out_vx(out_vx), .out_vy(out_vy), .out_class(out_class),
        .frame_done(frame_done), .meas_dropped(meas_dropped), .frame_overrun(frame_overrun)
    );

    typedef struct {
        bit                      done;
        logic [ID_W-1:0]         id;
        logic signed [POS_W-1:0] x, y, vx, vy;
        logic [CLASS_W-1:0]      cls;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    int ovr_cnt = 0;

    // Monitor: pops the scoreboard on every record handshake and frame_done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (meas_dropped) drop_cnt++;
            if (frame_overrun) ovr_cnt++;
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0 || exp_q[0].done) begin
                    fails++;
                    $display("FAIL record_unexpected: got id=%0d x=%0d y=%0d, required none", out_id, out_x, out_y);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_id !== e.id || out_x !== e.x || out_y !== e.y || out_vx !== e.vx ||
                        out_vy !== e.vy || out_class !== e.cls) begin
                        fails++;
                        $display("FAIL record: got id=%0d x=%0d y=%0d vx=%0d vy=%0d cls=%0d, required id=%0d x=%0d y=%0d vx=%0d vy=%0d cls=%0d",
                                 out_id, out_x, out_y, out_vx, out_vy, out_class, e.id, e.x, e.y, e.vx, e.vy, e.cls);
                    end
                end
            end
            if (frame_done) begin
                tests++;
                done_cnt++;
                if (exp_q.size() == 0 || !exp_q[0].done) begin
                    fails++;
                    $display("FAIL frame_done: got pulse with %0d queued, required done marker at head", exp_q.size());
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_rec(input int id, input int x, input int y, input int vx, input int vy, input int cls);
        exp_t e;
        e.done = 1'b0; e.id = ID_W'(id); e.x = x; e.y = y; e.vx = vx; e.vy = vy; e.cls = CLASS_W'(cls);
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.done = 1'b1; e.id = '0; e.x = 0; e.y = 0; e.vx = 0; e.vy = 0; e.cls = '0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; frame_tick = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_det(input int x, input int y, input int cls);
        int k;
        in_x = x; in_y = y; in_class = CLASS_W'(cls); in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            tests++; fails++;
            $display("FAIL det_accept: got no in_ready within %0d cycles, required acceptance", k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_done();
        int start, k;
        start = done_cnt; k = 0;
        while (done_cnt == start && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (done_cnt == start) begin
            tests++; fails++;
            $display("FAIL frame_done_wait: got no pulse in %0d cycles, required one", k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lat, rdy_seen, d0, o0;

        // Reset values, then reset in the middle of a dump with out_valid held high
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", in_ready, 1);
        chk("frame_done_idle", frame_done, 0);
        send_det(100, 200, 5);
        send_det(100, 200, 5);
        out_ready = 1'b0;
        tick();
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("dump_out_valid", out_valid, 1);
        chk("dump_out_x", out_x, 100);
        chk("dump_out_y", out_y, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        push_done();
        tick();
        wait_done();
        chk("queue_after_reset", exp_q.size(), 0);

        // Track birth, then update: x=105 vx=1, predicted x=106
        do_reset();
        send_det(100, 200, 7);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!in_ready && lat < 100);
        chk("in_ready_latency", lat, N + 2);
        @(posedge clk); #1;
        push_done();
        tick();
        wait_done();
        send_det(110, 200, 9);
        push_rec(0, 106, 200, 1, 0, 9);
        push_done();
        tick();
        wait_done();
        chk("queue_birth_update", exp_q.size(), 0);

        // Equal-distance tie goes to the lowest slot: x=75 vx=18, predicted 93
        do_reset();
        send_det(0, 0, 1);
        send_det(300, 0, 2);
        send_det(150, 0, 3);
        push_rec(0, 93, 0, 18, 0, 3);
        push_done();
        tick();
        wait_done();
        chk("queue_tie", exp_q.size(), 0);

        // Table full: 17th detection is dropped, slot 15 keeps its track
        do_reset();
        d0 = drop_cnt;
        for (int i = 0; i < 17; i++) send_det(i * 1000, 0, i);
        repeat (N + 4) @(posedge clk);
        #1;
        chk("meas_dropped_count", drop_cnt - d0, 1);
        send_det(15008, 0, 20);
        push_rec(15, 15005, 0, 1, 0, 20);
        push_done();
        tick();
        wait_done();
        chk("queue_full_table", exp_q.size(), 0);

        // Coasting: reported through 3 empty frames, deleted on the 4th, slot reused
        do_reset();
        send_det(5000, 5000, 4);
        send_det(5000, 5000, 4);
        for (int t = 0; t < 4; t++) begin
            push_rec(0, 5000, 5000, 0, 0, 4);
            push_done();
            tick();
            wait_done();
        end
        push_done();
        tick();
        wait_done();
        send_det(-7000, 0, 6);
        send_det(-7000, 0, 6);
        push_rec(0, -7000, 0, 0, 0, 6);
        push_done();
        tick();
        wait_done();
        chk("queue_coast", exp_q.size(), 0);

        // Two ticks during SEARCH: one overrun, one dump, in_ready back with frame_done
        do_reset();
        d0 = done_cnt; o0 = ovr_cnt;
        push_done();
        send_det(1, 1, 1);
        tick();
        tick();
        k = 0; rdy_seen = 0;
        while (!frame_done && k < 500) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            k++;
        end
        chk("frame_done_seen", frame_done, 1);
        chk("in_ready_low_until_done", rdy_seen, 0);
        chk("in_ready_at_frame_done", in_ready, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("overrun_count", ovr_cnt - o0, 1);
        chk("dump_count", done_cnt - d0, 1);
        chk("queue_overrun", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
